// File: rtl/rx_fsrc_ctrl.sv
// Sysref-epoch sequencer for the RX FSRC: arms on start, counts sysref epochs, and at
// programmed epochs updates the control word, fires stretched triggers and flags RX data start.
module rx_fsrc_ctrl #(
    parameter int CTRL_WIDTH    = 40,
    parameter int COUNTER_WIDTH = 4,
    parameter int NUM_TRIG      = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    sysref_int,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic [CTRL_WIDTH-1:0]                   next_ctrl_value,
    input  logic [COUNTER_WIDTH-1:0]                ctrl_change_cnt,
    input  logic [NUM_TRIG-1:0][COUNTER_WIDTH-1:0]  trig_cnt,
    input  logic [COUNTER_WIDTH-1:0]                data_start_cnt,
    output logic [CTRL_WIDTH-1:0]                   ctrl,
    output logic [NUM_TRIG-1:0]                     trig_out,
    output logic                                    rx_data_start,
    output logic                                    busy,
    output logic                                    done
);

    // state | meaning
    // IDLE  | waiting for start; shadows hold the last accepted configuration
    // ARMED | configuration captured, waiting for the aligning sysref
    // COUNT | counting sysref epochs and firing events on matches
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [COUNTER_WIDTH-1:0]               count;
    logic [COUNTER_WIDTH-1:0]               sh_ctrl_cnt;
    logic [COUNTER_WIDTH-1:0]               sh_data_cnt;
    logic [NUM_TRIG-1:0][COUNTER_WIDTH-1:0] sh_trig_cnt;
    logic [CTRL_WIDTH-1:0]                  sh_next_ctrl;
    logic                                   capture;
    logic                                   live_sysref;
    logic                                   hit_ctrl;
    logic                                   hit_data;
    logic [NUM_TRIG-1:0]                    hit_trig;
    logic [NUM_TRIG-1:0]                    trig_pulse;
    logic [NUM_TRIG-1:0][1:0]               stretch_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort masks every event, even with a coincident sysref
    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        hit_trig    = '0;
        live_sysref = (state == COUNT) && sysref_int && !abort;
        hit_ctrl    = live_sysref && (count == sh_ctrl_cnt);
        hit_data    = live_sysref && (count == sh_data_cnt);
        for (int i = 0; i < NUM_TRIG; i++) begin
            hit_trig[i] = live_sysref && (count == sh_trig_cnt[i]);
        end
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = ARMED;
                    capture    = 1'b1;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (sysref_int) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (abort || hit_data) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            sh_ctrl_cnt   <= '0;
            sh_data_cnt   <= '0;
            sh_trig_cnt   <= '0;
            sh_next_ctrl  <= '0;
            ctrl          <= '0;
            rx_data_start <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            trig_pulse    <= '0;
            stretch_cnt   <= '0;
            trig_out      <= '0;
        end else begin
            if (capture) begin
                sh_ctrl_cnt  <= ctrl_change_cnt;
                sh_data_cnt  <= data_start_cnt;
                sh_trig_cnt  <= trig_cnt;
                sh_next_ctrl <= next_ctrl_value;
            end
            // aligning sysref, abort and sequence end all leave the counter at zero
            if (state != COUNT || state_next != COUNT) begin
                count <= '0;
            end else if (sysref_int) begin
                count <= count + COUNTER_WIDTH'(1);
            end
            if (hit_ctrl) begin
                ctrl <= sh_next_ctrl;
            end
            rx_data_start <= hit_data;
            done          <= hit_data;
            busy          <= (state_next != IDLE);
            trig_pulse    <= hit_trig;
            // each pulse restarts a 4-cycle high window; abort does not cut it short
            for (int i = 0; i < NUM_TRIG; i++) begin
                if (trig_pulse[i]) begin
                    stretch_cnt[i] <= 2'd3;
                    trig_out[i]    <= 1'b1;
                end else if (stretch_cnt[i] != 2'd0) begin
                    stretch_cnt[i] <= stretch_cnt[i] - 2'd1;
                    trig_out[i]    <= 1'b1;
                end else begin
                    trig_out[i]    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_fsrc_ctrl.sv
// Bench for rx_fsrc_ctrl: directed scenarios plus randomized sequences, each checked
// against an epoch/event-schedule reference model.
module tb_rx_fsrc_ctrl;

    localparam int CW   = 40;
    localparam int CNTW = 4;
    localparam int NT   = 4;
    localparam int VW   = CW + NT + 3;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_COUNT = 2;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      sysref_int = 1'b0;
    logic                      start = 1'b0;
    logic                      abort = 1'b0;
    logic [CW-1:0]             next_ctrl_value = '0;
    logic [CNTW-1:0]           ctrl_change_cnt = '0;
    logic [NT-1:0][CNTW-1:0]   trig_cnt = '0;
    logic [CNTW-1:0]           data_start_cnt = '0;
    logic [CW-1:0]             ctrl;
    logic [NT-1:0]             trig_out;
    logic                      rx_data_start;
    logic                      busy;
    logic                      done;

    rx_fsrc_ctrl #(.CTRL_WIDTH(CW), .COUNTER_WIDTH(CNTW), .NUM_TRIG(NT)) dut (
        .clk             (clk),
        .reset           (reset),
        .sysref_int      (sysref_int),
        .start           (start),
        .abort           (abort),
        .next_ctrl_value (next_ctrl_value),
        .ctrl_change_cnt (ctrl_change_cnt),
        .trig_cnt        (trig_cnt),
        .data_start_cnt  (data_start_cnt),
        .ctrl            (ctrl),
        .trig_out        (trig_out),
        .rx_data_start   (rx_data_start),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cycle_n = 0;

    // reference model: sequence phase, epochs seen since alignment, and a schedule of trigger hits
    typedef struct { int idx; int cyc; } hit_t;
    hit_t      hits[$];
    int        m_phase = P_IDLE;
    int        m_epoch = 0;
    logic [CW-1:0] m_ctrl = '0;
    bit        m_rx = 1'b0;
    int        sh_ctrl = 0;
    int        sh_ds = 0;
    int        sh_trig[NT];
    logic [CW-1:0] sh_next = '0;

    task automatic model_step();
        hit_t h;
        if (reset) begin
            m_phase = P_IDLE;
            m_ctrl  = '0;
            m_rx    = 1'b0;
            sh_ctrl = 0;
            sh_ds   = 0;
            sh_next = '0;
            for (int i = 0; i < NT; i++) sh_trig[i] = 0;
            hits.delete();
            return;
        end
        m_rx = 1'b0;
        if (m_phase == P_IDLE) begin
            if (start && !abort) begin
                sh_ctrl = int'(ctrl_change_cnt);
                sh_ds   = int'(data_start_cnt);
                sh_next = next_ctrl_value;
                for (int i = 0; i < NT; i++) sh_trig[i] = int'(trig_cnt[i]);
                m_phase = P_ARMED;
            end
        end else if (abort) begin
            m_phase = P_IDLE;
        end else if (sysref_int) begin
            if (m_phase == P_ARMED) begin
                m_phase = P_COUNT;
                m_epoch = 0;
            end else begin
                if (m_epoch == sh_ctrl) m_ctrl = sh_next;
                for (int i = 0; i < NT; i++) begin
                    if (m_epoch == sh_trig[i]) begin
                        h.idx = i;
                        h.cyc = cycle_n;
                        hits.push_back(h);
                    end
                end
                if (m_epoch == sh_ds) begin
                    m_rx    = 1'b1;
                    m_phase = P_IDLE;
                end else begin
                    m_epoch++;
                end
            end
        end
        while (hits.size() > 0 && hits[0].cyc + 5 < cycle_n) void'(hits.pop_front());
    endtask

    // outputs expected after the most recent edge: a hit on input cycle p drives trig high on p+2..p+5
    function automatic logic [VW-1:0] exp_vec();
        logic [NT-1:0] t;
        t = '0;
        foreach (hits[k]) begin
            if (hits[k].cyc + 2 <= cycle_n && cycle_n <= hits[k].cyc + 5) t[hits[k].idx] = 1'b1;
        end
        return {m_ctrl, t, m_rx, m_rx, (m_phase != P_IDLE)};
    endfunction

    task automatic step(input bit s_sys, input bit s_start, input bit s_abort, input bit s_reset);
        sysref_int = s_sys;
        start      = s_start;
        abort      = s_abort;
        reset      = s_reset;
        model_step();
        @(posedge clk);
        #1;
        cycle_n++;
        sysref_int = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic load_cfg(input int cc, input int t0, input int t1, input int t2, input int t3,
                            input int ds, input logic [CW-1:0] nv);
        ctrl_change_cnt = CNTW'(cc);
        trig_cnt[0]     = CNTW'(t0);
        trig_cnt[1]     = CNTW'(t1);
        trig_cnt[2]     = CNTW'(t2);
        trig_cnt[3]     = CNTW'(t3);
        data_start_cnt  = CNTW'(ds);
        next_ctrl_value = nv;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1);
        step(0, 0, 0, 1);
        n_cmp++;
        if ({ctrl, trig_out, rx_data_start, done, busy} !== VW'(0)) begin
            n_mis++;
            $display("FAIL reset_zero got=%h exp=0", {ctrl, trig_out, rx_data_start, done, busy});
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            n_cmp++;
            if ({ctrl, trig_out, rx_data_start, done, busy} !== exp_vec()) begin
                n_mis++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cycle_n,
                         {ctrl, trig_out, rx_data_start, done, busy}, exp_vec());
            end
        end
    endtask

    // start, then five sysrefs 16 cycles apart; optionally rewrites inputs after arming
    task automatic test_normal(input string name, input bit change_after_arm, input bit second_start);
        int s4_cyc = -1, first_trig = -1, n_trig0 = 0, n_done = 0, n_rx = 0;
        step(0, 0, 0, 1);
        load_cfg(1, 2, 9, 9, 9, 3, 40'hA5);
        step(0, 1, 0, 0);
        if (change_after_arm) load_cfg(0, 0, 0, 0, 0, 1, 40'h11);
        for (int s = 0; s < 5; s++) begin
            if (s == 3) s4_cyc = cycle_n;
            for (int g = 0; g < 16; g++) begin
                step(g == 0, second_start && s == 1 && g == 3, 0, 0);
                if (trig_out[0]) begin
                    n_trig0++;
                    if (first_trig < 0) first_trig = cycle_n;
                end
                if (done) n_done++;
                if (rx_data_start) n_rx++;
                n_cmp++;
                if ({ctrl, trig_out, rx_data_start, done, busy} !== exp_vec()) begin
                    n_mis++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", name, cycle_n,
                             {ctrl, trig_out, rx_data_start, done, busy}, exp_vec());
                end
            end
        end
        n_cmp++;
        if (ctrl !== 40'hA5 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL %s_end ctrl=%h busy=%b exp ctrl=a5 busy=0", name, ctrl, busy);
        end
        n_cmp++;
        if (n_trig0 != 4 || first_trig - s4_cyc != 2) begin
            n_mis++;
            $display("FAIL %s_trig high=%0d offset=%0d exp 4 and 2", name, n_trig0, first_trig - s4_cyc);
        end
        n_cmp++;
        if (n_done != 1 || n_rx != 1) begin
            n_mis++;
            $display("FAIL %s_done done=%0d rx=%0d exp 1 and 1", name, n_done, n_rx);
        end
    endtask

    task automatic test_coincident();
        int n_all = 0;
        step(0, 0, 0, 1);
        load_cfg(0, 0, 0, 0, 0, 0, 40'h5A_0000_0001);
        step(0, 1, 0, 0);
        for (int g = 0; g < 24; g++) begin
            step(g == 2 || g == 6, 0, 0, 0);
            if (trig_out == '1) n_all++;
            n_cmp++;
            if ({ctrl, trig_out, rx_data_start, done, busy} !== exp_vec()) begin
                n_mis++;
                $display("FAIL coincident cyc=%0d got=%h exp=%h", cycle_n,
                         {ctrl, trig_out, rx_data_start, done, busy}, exp_vec());
            end
        end
        n_cmp++;
        if (n_all != 4 || ctrl !== 40'h5A_0000_0001) begin
            n_mis++;
            $display("FAIL coincident_end all_high=%0d ctrl=%h exp 4 and 5a00000001", n_all, ctrl);
        end
    endtask

    task automatic test_abort();
        int n_ev = 0;
        step(0, 0, 0, 1);
        load_cfg(1, 2, 2, 2, 2, 3, 40'h3C);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL abort_idle busy=%b exp 0", busy);
        end
        step(0, 1, 0, 0);
        for (int s = 0; s < 5; s++) begin
            for (int g = 0; g < 8; g++) begin
                step(g == 0, 0, s == 2 && g == 0, 0);
                if (trig_out != '0 || done || rx_data_start) n_ev++;
                n_cmp++;
                if ({ctrl, trig_out, rx_data_start, done, busy} !== exp_vec()) begin
                    n_mis++;
                    $display("FAIL abort cyc=%0d got=%h exp=%h", cycle_n,
                             {ctrl, trig_out, rx_data_start, done, busy}, exp_vec());
                end
            end
        end
        n_cmp++;
        if (n_ev != 0 || ctrl !== '0) begin
            n_mis++;
            $display("FAIL abort_end events=%0d ctrl=%h exp 0 and 0", n_ev, ctrl);
        end
    endtask

    task automatic test_mid_reset();
        step(0, 0, 0, 1);
        load_cfg(1, 2, 2, 2, 2, 3, 40'hA5);
        step(0, 1, 0, 0);
        for (int g = 0; g < 9; g++) step(g == 0 || g == 3 || g == 6 || g == 7, 0, 0, 0);
        step(0, 0, 0, 1);
        n_cmp++;
        if ({ctrl, trig_out, rx_data_start, done, busy} !== VW'(0)) begin
            n_mis++;
            $display("FAIL mid_reset got=%h exp=0", {ctrl, trig_out, rx_data_start, done, busy});
        end
        for (int g = 0; g < 8; g++) begin
            step(0, 0, 0, 0);
            n_cmp++;
            if ({ctrl, trig_out, rx_data_start, done, busy} !== exp_vec()) begin
                n_mis++;
                $display("FAIL mid_reset_after cyc=%0d got=%h exp=%h", cycle_n,
                         {ctrl, trig_out, rx_data_start, done, busy}, exp_vec());
            end
        end
        test_normal("after_reset", 0, 0);
    endtask

    // sequences ending on a trigger epoch, immediately re-armed with sysref every cycle
    task automatic test_back_to_back();
        step(0, 0, 0, 1);
        for (int r = 0; r < 3; r++) begin
            load_cfg(15, r, 0, 1, 15, r, CW'(r + 7));
            step(0, 1, 0, 0);
            for (int g = 0; g < r + 2; g++) begin
                step(1, 0, 0, 0);
                n_cmp++;
                if ({ctrl, trig_out, rx_data_start, done, busy} !== exp_vec()) begin
                    n_mis++;
                    $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cycle_n,
                             {ctrl, trig_out, rx_data_start, done, busy}, exp_vec());
                end
            end
        end
        load_cfg(15, 15, 15, 0, 15, 15, 40'hFF_FFFF_FFFF);
        step(0, 1, 0, 0);
        for (int g = 0; g < 24; g++) begin
            step(1, 0, 0, 0);
            n_cmp++;
            if ({ctrl, trig_out, rx_data_start, done, busy} !== exp_vec()) begin
                n_mis++;
                $display("FAIL max_epoch cyc=%0d got=%h exp=%h", cycle_n,
                         {ctrl, trig_out, rx_data_start, done, busy}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int seq = 0; seq < 30; seq++) begin
            load_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15),
                     ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 8),
                     {$urandom, $urandom});
            step(0, 1, 0, 0);
            for (int s = 0; s < 60 && m_phase != P_IDLE; s++) begin
                if ($urandom_range(0, 3) == 0) next_ctrl_value = {$urandom, $urandom};
                for (int g = $urandom_range(0, 3); g >= 0; g--) begin
                    step(g == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                         $urandom_range(0, 199) == 0);
                    n_cmp++;
                    if ({ctrl, trig_out, rx_data_start, done, busy} !== exp_vec()) begin
                        n_mis++;
                        $display("FAIL random seq=%0d cyc=%0d got=%h exp=%h", seq, cycle_n,
                                 {ctrl, trig_out, rx_data_start, done, busy}, exp_vec());
                    end
                end
            end
            for (int g = 0; g < 6; g++) begin
                step(0, 0, 0, 0);
                n_cmp++;
                if ({ctrl, trig_out, rx_data_start, done, busy} !== exp_vec()) begin
                    n_mis++;
                    $display("FAIL random_tail seq=%0d cyc=%0d got=%h exp=%h", seq, cycle_n,
                             {ctrl, trig_out, rx_data_start, done, busy}, exp_vec());
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NT; i++) sh_trig[i] = 0;
        test_reset();
        test_normal("normal", 0, 0);
        test_normal("input_change", 1, 0);
        test_normal("ignored_start", 0, 1);
        test_coincident();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/rx_fsrc_ctrl.md
RX_FSRC_CTRL -- requirements
Module: rx_fsrc_ctrl

Interface
REQ-001 Parameter CTRL_WIDTH, default 40: width of the RX FSRC control word.
REQ-002 Parameter COUNTER_WIDTH, default 4: width of the sysref epoch counter and of every count input.
REQ-003 Parameter NUM_TRIG, default 4: number of trigger outputs.
REQ-004 clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 sysref_int  input  1: single-cycle epoch pulse, synchronous to clk.
REQ-007 start  input  1: single-cycle arm request.
REQ-008 abort  input  1: single-cycle cancel request.
REQ-009 next_ctrl_value  input  CTRL_WIDTH: control word applied at ctrl_change_cnt.
REQ-010 ctrl_change_cnt  input  COUNTER_WIDTH: epoch at which ctrl is updated.
REQ-011 trig_cnt  input  NUM_TRIG x COUNTER_WIDTH: epoch at which each trig_out fires.
REQ-012 data_start_cnt  input  COUNTER_WIDTH: epoch at which rx_data_start pulses and the sequence ends.
REQ-013 ctrl  output  CTRL_WIDTH: registered control word to the RX FSRC.
REQ-014 trig_out  output  NUM_TRIG: stretched trigger pulses.
REQ-015 rx_data_start  output  1: single-cycle pulse marking the start of RX data.
REQ-016 busy  output  1: high while the state is not IDLE.
REQ-017 done  output  1: single-cycle pulse marking normal completion.

Function
REQ-018 The FSM SHALL have three states: IDLE, ARMED and COUNT.
REQ-019 IDLE -> ARMED on start; on that cycle ctrl_change_cnt, trig_cnt, data_start_cnt and next_ctrl_value SHALL be captured into shadow registers.
- All later input changes SHALL be ignored until the next accepted start.
REQ-020 start SHALL be ignored in ARMED and COUNT.
REQ-021 ARMED -> COUNT on sysref_int, with count <= 0.
- This first sysref_int SHALL only align the counter and SHALL fire no event.
REQ-022 In COUNT, each sysref_int SHALL increment count by 1.
- hit(N) = (state==COUNT && sysref_int && count==N), where N is a shadow value.
REQ-023 hit(ctrl_change_cnt) SHALL set ctrl <= shadow next_ctrl_value on the following clock edge.
- ctrl SHALL hold that value until a later hit or reset.
REQ-024 hit(trig_cnt[i]) SHALL generate an internal pulse, registered one cycle.
- The pulse SHALL be stretched so trig_out[i] is high exactly 4 consecutive cycles, starting 2 cycles after the hit cycle.
- A retrigger during a stretch SHALL extend the high time to 4 cycles after the latest pulse.
REQ-025 hit(data_start_cnt) SHALL assert rx_data_start and done for exactly 1 cycle on the following edge.
- On the same edge: state -> IDLE and count <= 0.
REQ-026 Events with the same N SHALL fire on the same cycle.
- Events with N > data_start_cnt SHALL never fire.
- Events with N == data_start_cnt SHALL fire together with rx_data_start.
REQ-027 The counter SHALL NOT wrap: the sequence ends at data_start_cnt, whose maximum is 2^COUNTER_WIDTH-1.
REQ-028 abort in ARMED or COUNT SHALL return to IDLE on the next edge with count <= 0.
- No event SHALL fire on the abort cycle, even if sysref_int is coincident.
- done and rx_data_start SHALL NOT pulse.
- ctrl SHALL be unchanged.
- Any trig_out stretch already launched SHALL complete.
REQ-029 abort in IDLE SHALL have no effect.
- start and abort on the same cycle in IDLE SHALL leave the state IDLE.
REQ-030 busy SHALL be registered and SHALL equal (state != IDLE).

Reset
REQ-031 On reset the state SHALL be IDLE and count and shadows 0.
- Outputs ctrl=0, trig_out=0, rx_data_start=0, busy=0, done=0.
- Stretch registers SHALL be cleared.
REQ-032 Reset mid-sequence SHALL cancel the sequence identically to power-on reset, with reset taking priority over start, abort and sysref_int.

Verification
REQ-033 Normal sequence: ctrl_change_cnt=1, trig_cnt[0]=2, data_start_cnt=3, next_ctrl_value=0xA5; start, then 5 sysref_int pulses 16 cycles apart.
- ctrl=0xA5 one cycle after the 3rd sysref.
- trig_out[0] high 4 cycles starting 2 cycles after the 4th sysref.
- rx_data_start and done pulse 1 cycle after the 5th sysref.
- busy low afterward.
REQ-034 Input change after arm: change next_ctrl_value to 0x11 after start.
- ctrl still becomes 0xA5.
REQ-035 Coincident events: all counts = 0.
- ctrl update, every trig_out and rx_data_start all fire from the 2nd sysref.
REQ-036 Abort: abort coincident with the 3rd sysref in REQ-033 config.
- No ctrl change, no trig_out, no rx_data_start, no done.
- busy low next cycle.
REQ-037 Ignored start: second start while busy.
- Sequence timing unchanged from REQ-033.
- Exactly one done pulse.
REQ-038 Mid-sequence reset: reset during COUNT.
- All outputs 0 next cycle.
- A new start then behaves as in REQ-033.
